// File: rtl/ex_stage_if.sv
// ID/EX pipeline register bundle: control and data fields handed from decode to execute.
interface idex_if #(
  parameter int unsigned XLEN = 32
);
  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [3:0] ALUControl;
    logic       ALUSrc;
    logic       SrcAsrc;
    logic [2:0] funct3;
    logic       jumpReg;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] PCPlus4;
    logic [4:0]      Rs1;
    logic [4:0]      Rs2;
    logic [4:0]      Rd;
  } data_t;

  ctrl_t ctrl;
  data_t data;

  modport rd (input ctrl, input data);
  modport wr (output ctrl, output data);
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM pipeline register.
// Only XLEN = 32 is supported.
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  idex_if.rd              idex,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallM,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [2:0]      funct3M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM
);

  localparam int unsigned SHW = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] jr_sum;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;
  logic            br_take;

  // Register sources are consumed by the hazard unit, not here.
  logic unused_rs;
  assign unused_rs = ^{idex.data.Rs1, idex.data.Rs2};

  // Forwarding muxes; select 11 falls back to the register file value.
  always_comb begin
    src_a = idex.data.RD1;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = idex.data.RD1;
    endcase
    write_data = idex.data.RD2;
    case (ForwardBE)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = ALUResultM;
      default: write_data = idex.data.RD2;
    endcase
  end

  assign alu_a = idex.ctrl.SrcAsrc ? idex.data.PC     : src_a;
  assign alu_b = idex.ctrl.ALUSrc  ? idex.data.ImmExt : write_data;
  assign shamt = alu_b[SHW-1:0];

  always_comb begin
    alu_y = '0;
    case (idex.ctrl.ALUControl)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SLT:  alu_y = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_y = XLEN'(alu_a < alu_b);
      ALU_SLL:  alu_y = alu_a << shamt;
      ALU_SRL:  alu_y = alu_a >> shamt;
      ALU_SRA:  alu_y = XLEN'($signed(alu_a) >>> shamt);
      ALU_PASS: alu_y = alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Branch compare always uses the forwarded register operands, never PC/immediate.
  assign br_eq  = (src_a == write_data);
  assign br_lt  = ($signed(src_a) < $signed(write_data));
  assign br_ltu = (src_a < write_data);

  always_comb begin
    br_take = 1'b0;
    case (idex.ctrl.funct3)
      3'b000:  br_take = br_eq;
      3'b001:  br_take = ~br_eq;
      3'b100:  br_take = br_lt;
      3'b101:  br_take = ~br_lt;
      3'b110:  br_take = br_ltu;
      3'b111:  br_take = ~br_ltu;
      default: br_take = 1'b0;
    endcase
  end

  assign PCSrcE    = idex.ctrl.Jump | (idex.ctrl.Branch & br_take);
  assign jr_sum    = src_a + idex.data.ImmExt;
  assign PCTargetE = idex.ctrl.jumpReg ? {jr_sum[XLEN-1:1], 1'b0}
                                       : idex.data.PC + idex.data.ImmExt;

  // EX/MEM register: reset beats flush beats stall; flush only bubbles control.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      funct3M    <= 3'b000;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= 5'd0;
    end else if (FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      funct3M    <= 3'b000;
      ALUResultM <= alu_y;
      WriteDataM <= write_data;
      PCPlus4M   <= idex.data.PCPlus4;
      RdM        <= idex.data.Rd;
    end else if (!StallM) begin
      RegWriteM  <= idex.ctrl.RegWrite;
      MemWriteM  <= idex.ctrl.MemWrite;
      ResultSrcM <= idex.ctrl.ResultSrc;
      funct3M    <= idex.ctrl.funct3;
      ALUResultM <= alu_y;
      WriteDataM <= write_data;
      PCPlus4M   <= idex.data.PCPlus4;
      RdM        <= idex.data.Rd;
    end
  end

endmodule
